// File: rtl/fnd_scan_ctrl.sv
// rtl/fnd_scan_ctrl.sv - multiplexed common-anode 7-segment scan controller
//
// Purpose:
//   Scans NUM_DIGITS common-anode digits, one slot of SCAN_DIV clocks per
//   digit. Each slot begins with BLANK_CYC clocks where every common is off,
//   so the previous digit's segments cannot ghost onto the next one. The
//   digit values are sampled once per frame, so a frame never shows a mix of
//   old and new data. The block also does hex font decode, per-digit decimal
//   points and optional leading-zero suppression.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   en          scan enable; low = display dark, counters hold
//   digit_data  hex nibbles, digit k = [4k+3:4k], digit 0 = rightmost
//   dp_in       decimal point per digit, 1 = lit
//   blank_lz    1 = suppress leading zeros
//   sel         index of the digit owning the current slot
//   fnd_com     commons, active-low one-hot (bit k drives digit k)
//   fnd_font    segments {dp,g,f,e,d,c,b,a}, active-low
//   frame_tick  one-cycle pulse when sel wraps back to 0

module fnd_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int BLANK_CYC  = 16,
  localparam int SEL_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [SEL_W-1:0]        sel,
  output logic [NUM_DIGITS-1:0]   fnd_com,
  output logic [7:0]              fnd_font,
  output logic                    frame_tick
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_t;

  // Scan position
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SEL_W-1:0]        sel_q, sel_d;

  // Frame snapshot of the inputs
  logic [4*NUM_DIGITS-1:0] snap_data_q, snap_data_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic                    snap_blz_q, snap_blz_d;

  // Registered pin drivers
  logic [NUM_DIGITS-1:0]   com_q, com_d;
  logic [7:0]              font_q, font_d;
  logic                    tick_q, tick_d;

  // Decode helpers
  phase_t                  phase;
  logic                    slot_end;
  logic                    last_digit;
  logic                    frame_start;
  logic                    all_zero;
  logic [NUM_DIGITS-1:0]   supp;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_supp;

  // Hex font, segments g..a, active-low (dp handled separately)
  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Slot / frame position decode
  always_comb begin
    slot_end    = (cnt_q == CNT_W'(SCAN_DIV - 1));
    last_digit  = (sel_q == SEL_W'(NUM_DIGITS - 1));
    frame_start = (cnt_q == '0) && (sel_q == '0);
    phase       = (cnt_q < CNT_W'(BLANK_CYC)) ? PH_BLANK : PH_DRIVE;
  end

  // Next state: prescaler, digit select, frame snapshot, frame tick
  always_comb begin
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    snap_data_d = snap_data_q;
    snap_dp_d   = snap_dp_q;
    snap_blz_d  = snap_blz_q;
    tick_d      = 1'b0;

    if (en) begin
      if (slot_end) begin
        cnt_d  = '0;
        // Explicit wrap so sel never reaches NUM_DIGITS when it is not a power of 2
        sel_d  = last_digit ? '0 : sel_q + SEL_W'(1);
        // Registered, so the pulse lands in the cycle where cnt=0, sel=0
        tick_d = last_digit;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      // Sampling at the first cycle of slot 0 keeps a whole frame coherent
      if (frame_start) begin
        snap_data_d = digit_data;
        snap_dp_d   = dp_in;
        snap_blz_d  = blank_lz;
      end
    end
  end

  // Leading-zero suppression: walk down from the leftmost digit while every
  // nibble seen so far is zero. Digit 0 is never suppressed so "0" shows.
  always_comb begin
    supp     = '0;
    all_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      all_zero = all_zero & (snap_data_q[4*k +: 4] == 4'h0);
      supp[k]  = all_zero & snap_blz_q;
    end
  end

  // Select the snapshot fields for the current slot. Compare-based mux so an
  // out-of-range sel code (NUM_DIGITS not a power of 2) selects nothing.
  always_comb begin
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_supp = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (sel_q == SEL_W'(k)) begin
        cur_nib  = snap_data_q[4*k +: 4];
        cur_dp   = snap_dp_q[k];
        cur_supp = supp[k];
      end
    end
  end

  // Pin drivers: dark during BLANK and while disabled, else one common low
  always_comb begin
    com_d  = '1;
    font_d = 8'hFF;
    if (en && (phase == PH_DRIVE)) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (sel_q == SEL_W'(k)) begin
          com_d[k] = 1'b0;
        end
      end
      font_d = {~cur_dp, (cur_supp ? 7'h7F : hex_font(cur_nib))};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      sel_q       <= '0;
      snap_data_q <= '0;
      snap_dp_q   <= '0;
      snap_blz_q  <= 1'b0;
      com_q       <= '1;
      font_q      <= 8'hFF;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      snap_data_q <= snap_data_d;
      snap_dp_q   <= snap_dp_d;
      snap_blz_q  <= snap_blz_d;
      com_q       <= com_d;
      font_q      <= font_d;
      tick_q      <= tick_d;
    end
  end

  assign sel        = sel_q;
  assign fnd_com    = com_q;
  assign fnd_font   = font_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb/tb_fnd_scan_ctrl.sv - directed self-checking bench for fnd_scan_ctrl

module tb_fnd_scan_ctrl;

  logic        clk;
  logic        reset;
  logic        en;
  logic [15:0] digit_data;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [1:0]  sel;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_font;
  logic        frame_tick;

  logic        reset3;
  logic        en3;
  logic [11:0] digit_data3;
  logic [2:0]  dp_in3;
  logic        blank_lz3;
  logic [1:0]  sel3;
  logic [2:0]  fnd_com3;
  logic [7:0]  fnd_font3;
  logic        frame_tick3;

  int checks;
  int failures;
  int k;

  fnd_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .digit_data (digit_data),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .sel        (sel),
    .fnd_com    (fnd_com),
    .fnd_font   (fnd_font),
    .frame_tick (frame_tick)
  );

  fnd_scan_ctrl #(.NUM_DIGITS(3), .SCAN_DIV(8), .BLANK_CYC(2)) u_dut3 (
    .clk        (clk),
    .reset      (reset3),
    .en         (en3),
    .digit_data (digit_data3),
    .dp_in      (dp_in3),
    .blank_lz   (blank_lz3),
    .sel        (sel3),
    .fnd_com    (fnd_com3),
    .fnd_font   (fnd_font3),
    .frame_tick (frame_tick3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance ncyc enabled clocks from the current scan position k and compare
  // against the expected slot pattern: 2 blank cycles then 6 drive cycles.
  task automatic scan_check(input int ncyc, input logic [7:0] f0, input logic [7:0] f1,
                            input logic [7:0] f2, input logic [7:0] f3);
    logic [7:0] ef [4];
    logic [3:0] exp_com;
    logic [7:0] exp_font;
    int c;
    int slot;
    ef[0] = f0; ef[1] = f1; ef[2] = f2; ef[3] = f3;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      k++;
      c    = (k - 1) % 8;
      slot = ((k - 1) / 8) % 4;
      exp_com  = (c < 2) ? 4'hF : ~(4'b0001 << slot);
      exp_font = (c < 2) ? 8'hFF : ef[slot];
      check($sformatf("com k=%0d", k), 32'(fnd_com), 32'(exp_com));
      check($sformatf("font k=%0d", k), 32'(fnd_font), 32'(exp_font));
      check($sformatf("sel k=%0d", k), 32'(sel), 32'((k / 8) % 4));
      check($sformatf("tick k=%0d", k), 32'(frame_tick), 32'(k % 32 == 0));
      check($sformatf("onehot k=%0d", k), 32'($countones(~fnd_com) <= 1), 32'd1);
    end
  endtask

  task automatic dark_check(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      check($sformatf("en0 com i=%0d", i), 32'(fnd_com), 32'hF);
      check($sformatf("en0 font i=%0d", i), 32'(fnd_font), 32'hFF);
      check($sformatf("en0 tick i=%0d", i), 32'(frame_tick), 32'd0);
      check($sformatf("en0 sel i=%0d", i), 32'(sel), 32'((k / 8) % 4));
    end
  endtask

  initial begin
    logic [7:0] ef3 [3];
    logic [2:0] exp_com3;
    int c3;
    int s3;

    checks   = 0;
    failures = 0;
    k        = 0;

    reset       = 1'b1;
    en          = 1'b1;
    digit_data  = 16'h1234;
    dp_in       = 4'b0000;
    blank_lz    = 1'b0;
    reset3      = 1'b1;
    en3         = 1'b1;
    digit_data3 = 12'h123;
    dp_in3      = 3'b000;
    blank_lz3   = 1'b0;

    repeat (3) @(negedge clk);
    check("rst com", 32'(fnd_com), 32'hF);
    check("rst font", 32'(fnd_font), 32'hFF);
    check("rst tick", 32'(frame_tick), 32'd0);
    check("rst sel", 32'(sel), 32'd0);
    check("rst3 com", 32'(fnd_com3), 32'h7);
    check("rst3 sel", 32'(sel3), 32'd0);

    // Basic scan of 1234, two frames
    reset = 1'b0;
    scan_check(64, 8'h99, 8'hB0, 8'hA4, 8'hF9);

    // Leading-zero suppression with dp on digit 0, then without suppression
    digit_data = 16'h0070;
    dp_in      = 4'b0001;
    blank_lz   = 1'b1;
    scan_check(32, 8'h40, 8'hF8, 8'hFF, 8'hFF);
    blank_lz   = 1'b0;
    scan_check(32, 8'h40, 8'hF8, 8'hC0, 8'hC0);

    // Mid-frame data change is held off until the next frame
    digit_data = 16'h1111;
    dp_in      = 4'b0000;
    scan_check(52, 8'hF9, 8'hF9, 8'hF9, 8'hF9);
    digit_data = 16'h2222;
    scan_check(12, 8'hF9, 8'hF9, 8'hF9, 8'hF9);
    scan_check(32, 8'hA4, 8'hA4, 8'hA4, 8'hA4);

    // Enable dropped mid-DRIVE of slot 1; slot resumes where it stopped
    scan_check(13, 8'hA4, 8'hA4, 8'hA4, 8'hA4);
    en = 1'b0;
    dark_check(20);
    en = 1'b1;
    scan_check(19, 8'hA4, 8'hA4, 8'hA4, 8'hA4);

    // Async reset mid-DRIVE of slot 3
    scan_check(28, 8'hA4, 8'hA4, 8'hA4, 8'hA4);
    reset = 1'b1;
    #1;
    check("arst com", 32'(fnd_com), 32'hF);
    check("arst font", 32'(fnd_font), 32'hFF);
    check("arst sel", 32'(sel), 32'd0);
    check("arst tick", 32'(frame_tick), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    k     = 0;
    scan_check(40, 8'hA4, 8'hA4, 8'hA4, 8'hA4);

    // Three-digit instance: non-power-of-2 wrap
    ef3[0] = 8'hB0; ef3[1] = 8'hA4; ef3[2] = 8'hF9;
    reset3 = 1'b0;
    for (int k3 = 1; k3 <= 48; k3++) begin
      @(negedge clk);
      c3 = (k3 - 1) % 8;
      s3 = ((k3 - 1) / 8) % 3;
      exp_com3 = (c3 < 2) ? 3'b111 : ~(3'b001 << s3);
      check($sformatf("d3 com k=%0d", k3), 32'(fnd_com3), 32'(exp_com3));
      check($sformatf("d3 font k=%0d", k3), 32'(fnd_font3), 32'((c3 < 2) ? 8'hFF : ef3[s3]));
      check($sformatf("d3 sel k=%0d", k3), 32'(sel3), 32'((k3 / 8) % 3));
      check($sformatf("d3 tick k=%0d", k3), 32'(frame_tick3), 32'(k3 % 24 == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
